// File: rtl/mem_stage_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl_if
//
// Bundles the MEM-stage request/response signals and the external 16-bit
// SRAM pad signals used by mem_stage_sram_ctrl.
//
// Signals:
//   rd_en, wr_en    : read / write request (held stable while ready = 0)
//   address         : 32-bit processor byte address
//   write_data      : 32-bit store data
//   read_data       : 32-bit load data (registered in the controller)
//   ready           : 0 freezes the pipeline
//   sram_addr       : half-word SRAM address
//   sram_dq_out     : write data toward the pads
//   sram_dq_in      : read data from the pads
//   sram_dq_oe      : pad output enable
//   sram_we_n       : active-low SRAM write strobe
//
// Modports:
//   master : the environment around the controller (MEM stage + pads); it
//            drives the requests and the pad read data.
//   slave  : the controller itself.
// ---------------------------------------------------------------------------
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   rd_en;
  logic                   wr_en;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic [15:0]            sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//
// Sequences a 32-bit MEM-stage data access onto a 16-bit external SRAM as a
// low half-word transaction followed by a high half-word transaction, each
// held for WAIT_CYCLES+1 cycles. While an access is in flight, ready is low
// so the pipeline freezes. A one-cycle DONE state presents the result with
// ready high before returning to IDLE.
//
// Parameters:
//   BASE_ADDR    : processor byte address mapped to SRAM word 0
//   SRAM_ADDR_W  : SRAM half-word address width
//   WAIT_CYCLES  : extra cycles per half-word access (0..7)
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : request/response and SRAM pad signals (slave side)
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;

  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            sram_dq_out_q, sram_dq_out_d;
  logic                   sram_dq_oe_q, sram_dq_oe_d;
  logic                   sram_we_n_q, sram_we_n_d;

  logic                   req;
  logic                   last_cycle;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] word_addr;
  logic                   unused_offset_bits;

  assign req        = bus.rd_en | bus.wr_en;
  assign last_cycle = (cnt_q == WAIT_C);

  // Offset wraps mod 2^32; bits above the SRAM range and the byte lane
  // bits are intentionally dropped.
  assign offset             = bus.address - BASE_ADDR;
  assign word_addr          = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  // ready is combinational so a request is stalled in the same cycle it
  // first appears in IDLE.
  assign bus.ready = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);

  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;
  assign bus.sram_we_n   = sram_we_n_q;

  // Sequencing FSM: next state, wait counter and latched operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          cnt_d   = 3'd0;
          op_wr_d = bus.wr_en;  // write wins when both enables are set
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        if (last_cycle) begin
          state_d = S_HI;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HI: begin
        if (last_cycle) begin
          state_d = S_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        op_wr_d = 1'b0;
      end
    endcase
  end

  // Pad outputs are decoded from the next state so they take their LO
  // values on the very edge that enters LO.
  always_comb begin
    sram_addr_d   = {SRAM_ADDR_W{1'b0}};
    sram_dq_out_d = 16'h0000;
    sram_dq_oe_d  = 1'b0;
    sram_we_n_d   = 1'b1;
    case (state_d)
      S_LO: begin
        sram_addr_d = {word_addr, 1'b0};
        if (op_wr_d) begin
          sram_dq_out_d = bus.write_data[15:0];
          sram_dq_oe_d  = 1'b1;
          sram_we_n_d   = 1'b0;
        end else begin
          sram_dq_out_d = 16'h0000;
        end
      end
      S_HI: begin
        sram_addr_d = {word_addr, 1'b1};
        if (op_wr_d) begin
          sram_dq_out_d = bus.write_data[31:16];
          sram_dq_oe_d  = 1'b1;
          sram_we_n_d   = 1'b0;
        end else begin
          sram_dq_out_d = 16'h0000;
        end
      end
      default: begin
        sram_addr_d = {SRAM_ADDR_W{1'b0}};
      end
    endcase
  end

  // Read data capture on the last cycle of each half; writes leave it alone.
  always_comb begin
    read_data_d = read_data_q;
    if (!op_wr_q && last_cycle && (state_q == S_LO)) begin
      read_data_d[15:0] = bus.sram_dq_in;
    end else if (!op_wr_q && last_cycle && (state_q == S_HI)) begin
      read_data_d[31:16] = bus.sram_dq_in;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      op_wr_q       <= 1'b0;
      read_data_q   <= 32'h0000_0000;
      sram_addr_q   <= {SRAM_ADDR_W{1'b0}};
      sram_dq_out_q <= 16'h0000;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

  typedef struct {
    logic        wr;
    int          busy;
    logic [31:0] rd;
  } acc_t;

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wh_t;

  logic clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  acc_t acc_q1[$];
  wh_t  wr_q1[$];
  acc_t acc_q0[$];
  int   busy1 = 0;
  int   busy0 = 0;

  logic [15:0] mem1 [0:63];

  mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) bus1 ();
  mem_stage_sram_ctrl_if #(.SRAM_ADDR_W(18)) bus0 ();

  mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: dut1 uses a small writable array, dut0 a fixed word 0.
  assign bus1.sram_dq_in = mem1[bus1.sram_addr[5:0]];
  assign bus0.sram_dq_in = (bus0.sram_addr == 18'd0) ? 16'h5678 :
                           (bus0.sram_addr == 18'd1) ? 16'h1234 : 16'h0000;

  always @(negedge clk) begin
    if (rst && !bus1.sram_we_n) mem1[bus1.sram_addr[5:0]] <= bus1.sram_dq_out;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor for the W=1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      busy1 = 0;
    end else begin
      if (!bus1.sram_we_n) begin
        if (wr_q1.size() == 0) begin
          chk("spurious_write", 32'd1, 32'd0);
        end else begin
          wh_t w;
          w = wr_q1.pop_front();
          chk("wr_addr", 32'(bus1.sram_addr), w.a);
          chk("wr_data", 32'(bus1.sram_dq_out), 32'(w.d));
          chk("wr_oe", 32'(bus1.sram_dq_oe), 32'd1);
        end
      end
      if (!bus1.ready) begin
        busy1++;
        if (acc_q1.size() > 0 && !acc_q1[0].wr) begin
          chk("rd_we_n", 32'(bus1.sram_we_n), 32'd1);
          chk("rd_oe", 32'(bus1.sram_dq_oe), 32'd0);
        end
      end else if (busy1 > 0) begin
        if (acc_q1.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          acc_t e;
          e = acc_q1.pop_front();
          chk("freeze_len", 32'(busy1), 32'(e.busy));
          chk("read_data", bus1.read_data, e.rd);
          chk("done_addr", 32'(bus1.sram_addr), 32'd0);
          chk("done_we_n", 32'(bus1.sram_we_n), 32'd1);
          chk("done_oe", 32'(bus1.sram_dq_oe), 32'd0);
        end
        busy1 = 0;
      end
    end
  end

  // Monitor for the W=0 instance.
  always @(negedge clk) begin
    if (!rst) begin
      busy0 = 0;
    end else if (!bus0.ready) begin
      busy0++;
      chk("w0_oe", 32'(bus0.sram_dq_oe), 32'd0);
    end else if (busy0 > 0) begin
      if (acc_q0.size() == 0) begin
        chk("w0_unexpected_done", 32'd1, 32'd0);
      end else begin
        acc_t e;
        e = acc_q0.pop_front();
        chk("w0_freeze_len", 32'(busy0), 32'(e.busy));
        chk("w0_read_data", bus0.read_data, e.rd);
      end
      busy0 = 0;
    end
  end

  task automatic wait_done1();
    bit seen_busy = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (!bus1.ready) seen_busy = 1'b1;
      else if (seen_busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout_dut1", 32'd1, 32'd0);
    bus1.rd_en = 1'b0;
    bus1.wr_en = 1'b0;
  endtask

  // exp_a is the hand-computed SRAM half-word address of the low half.
  task automatic access1(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_a,
                         input logic [31:0] exp_rd, input int exp_busy);
    acc_t e;
    wh_t  w;
    e.wr = wr; e.busy = exp_busy; e.rd = exp_rd;
    acc_q1.push_back(e);
    if (wr) begin
      for (int k = 0; k < 2; k++) begin
        w.a = exp_a; w.d = wdata[15:0];
        wr_q1.push_back(w);
      end
      for (int k = 0; k < 2; k++) begin
        w.a = exp_a + 32'd1; w.d = wdata[31:16];
        wr_q1.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    bus1.rd_en = rd;
    bus1.wr_en = wr;
    bus1.address = addr;
    bus1.write_data = wdata;
    wait_done1();
  endtask

  task automatic read0(input logic [31:0] addr, input logic [31:0] exp_rd);
    acc_t e;
    bit seen_busy = 1'b0;
    bit ok = 1'b0;
    e.wr = 1'b0; e.busy = 3; e.rd = exp_rd;
    acc_q0.push_back(e);
    @(posedge clk);
    #1;
    bus0.rd_en = 1'b1;
    bus0.address = addr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (!bus0.ready) seen_busy = 1'b1;
      else if (seen_busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout_dut0", 32'd1, 32'd0);
    bus0.rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem1[i] = 16'h0000;
    rst = 1'b0;
    bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = 32'd0; bus1.write_data = 32'd0;
    bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = 32'd0; bus0.write_data = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus1.ready), 32'd1);
    chk("rst_we_n", 32'(bus1.sram_we_n), 32'd1);
    chk("rst_oe", 32'(bus1.sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(bus1.sram_addr), 32'd0);
    chk("rst_dq_out", 32'(bus1.sram_dq_out), 32'd0);
    chk("rst_read_data", bus1.read_data, 32'd0);
    chk("rst_ready_w0", 32'(bus0.ready), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xDEADBEEF at 1028 -> half-words 2 and 3.
    access1(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 32'd2, 32'h0000_0000, 5);
    // Read it back.
    access1(1'b1, 1'b0, 32'd1028, 32'h0000_0000, 32'd2, 32'hDEAD_BEEF, 5);
    // Both enables: write wins at half-words 4 and 5, read_data unchanged.
    access1(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, 32'd4, 32'hDEAD_BEEF, 5);
    // Confirm the write landed.
    access1(1'b1, 1'b0, 32'd1032, 32'h0000_0000, 32'd4, 32'hA5A5_0F0F, 5);

    // W=0 read of word 0.
    read0(32'd1024, 32'h1234_5678);

    // Reset during HI of a write to 1040 (half-words 8, 9): only LO lands.
    begin
      wh_t w;
      w.a = 32'd8; w.d = 16'h2222;
      wr_q1.push_back(w);
      wr_q1.push_back(w);
    end
    @(posedge clk);
    #1;
    bus1.wr_en = 1'b1;
    bus1.address = 32'd1040;
    bus1.write_data = 32'h1111_2222;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_hi_addr", 32'(bus1.sram_addr), 32'd9);
    #1;
    rst = 1'b0;
    bus1.wr_en = 1'b0;
    #1;
    chk("abort_we_n", 32'(bus1.sram_we_n), 32'd1);
    chk("abort_oe", 32'(bus1.sram_dq_oe), 32'd0);
    chk("abort_addr", 32'(bus1.sram_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(bus1.ready), 32'd1);
    chk("post_rst_read_data", bus1.read_data, 32'd0);

    // Read after abort: low half written, high half still zero.
    access1(1'b1, 1'b0, 32'd1040, 32'h0000_0000, 32'd8, 32'h0000_2222, 5);

    repeat (4) @(negedge clk);
    chk("wr_queue_empty", 32'(wr_q1.size()), 32'd0);
    chk("acc_queue_empty", 32'(acc_q1.size()), 32'd0);
    chk("acc0_queue_empty", 32'(acc_q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
